// File: rtl/jk_cmd_seq.sv
// ---------------------------------------------------------------------------
// jk_cmd_seq
//   Command sequencer that sits directly upstream of a JK flip-flop (jff).
//   {j,k} commands are buffered in a small FIFO. Each one is then driven onto
//   the flop's j/k inputs for HOLD cycles, followed by one CHECK cycle with
//   j=k=0. A cycle-exact JK model (exp_q) tracks what the flop's q should be.
//   In CHECK, exp_q is compared with the flop's q (q_fb). A difference raises
//   a one-cycle mismatch pulse and bumps a saturating error counter.
//
// Parameters
//   DEPTH  command FIFO entries (power of 2, >= 2)
//   HOLD   cycles each command is held on j/k (>= 1)
//   CW     width of err_cnt
//
// Ports
//   clk        rising-edge clock, shared with the jff
//   rst        asynchronous active-low reset, shared with the jff
//   cmd_valid  command offered
//   cmd_data   {j,k}: 10 set, 01 reset, 00 hold, 11 toggle
//   cmd_ready  FIFO can accept (not full)
//   q_fb       q output of the downstream jff
//   j, k       registered drive to the jff
//   busy       sequencer active or FIFO non-empty
//   exp_q      registered model of the jff q
//   mismatch   one-cycle pulse per failed check
//   err_cnt    saturating count of failed checks
// ---------------------------------------------------------------------------
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 1,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  input  logic [1:0]    cmd_data,
  output logic          cmd_ready,
  input  logic          q_fb,
  output logic          j,
  output logic          k,
  output logic          busy,
  output logic          exp_q,
  output logic          mismatch,
  output logic [CW-1:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HW-1:0] HCNT_INIT = HW'(HOLD - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK
  } state_t;

  // FIFO storage and bookkeeping
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // Sequencer state
  state_t        r_state;
  logic [HW-1:0] r_hcnt;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Acceptance looks only at full: a pop in the same cycle does not open a slot.
  assign w_push  = cmd_valid && !w_full;
  // The FSM takes the next command whenever it leaves IDLE or CHECK.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) || (r_state == S_CHECK));
  assign w_head  = r_mem[r_rd_ptr];

  assign cmd_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;

  // NOTE: the command storage has no reset; emptiness is defined by the
  // pointers and count alone, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cmd_data;
    end
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are AW bits wide, so they wrap at DEPTH on their own.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sequencer FSM with registered j/k, mismatch and err_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_hcnt   <= '0;
      j        <= 1'b0;
      k        <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      mismatch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {j, k}  <= w_head;
            r_hcnt  <= HCNT_INIT;
            r_state <= S_DRIVE;
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end

        S_DRIVE: begin
          if (r_hcnt == '0) begin
            j       <= 1'b0;
            k       <= 1'b0;
            r_state <= S_CHECK;
          end else begin
            r_hcnt <= r_hcnt - HW'(1);
          end
        end

        S_CHECK: begin
          // q_fb and exp_q were both updated by the last driven edge.
          if (q_fb != exp_q) begin
            mismatch <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + CW'(1);
          end
          if (w_pop) begin
            {j, k}  <= w_head;
            r_hcnt  <= HCNT_INIT;
            r_state <= S_DRIVE;
          end else begin
            j       <= 1'b0;
            k       <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          j       <= 1'b0;
          k       <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Reference JK model, clocked from the same registered j/k the flop sees.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= 1'b0;
    end else begin
      exp_q <= (j & ~exp_q) | (~k & exp_q);
    end
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_seq
//   Directed bench for jk_cmd_seq. Instance A (HOLD=1) drives a behavioural
//   JK flop whose q can be forced to 0; instance B (HOLD=2) drives its own
//   flop. Expected values are hand-derived per cycle.
// ---------------------------------------------------------------------------
module tb_jk_cmd_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: HOLD=1
  logic       a_valid = 1'b0;
  logic [1:0] a_data  = 2'b00;
  logic       a_ready, a_qfb, a_j, a_k, a_busy, a_expq, a_mm;
  logic [7:0] a_err;
  logic       qa;
  logic       tie0 = 1'b0;

  // Instance B: HOLD=2
  logic       b_valid = 1'b0;
  logic [1:0] b_data  = 2'b00;
  logic       b_ready, b_j, b_k, b_busy, b_expq, b_mm;
  logic [7:0] b_err;
  logic       qb;

  jk_cmd_seq #(.DEPTH(4), .HOLD(1), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_data(a_data),
    .cmd_ready(a_ready), .q_fb(a_qfb), .j(a_j), .k(a_k), .busy(a_busy),
    .exp_q(a_expq), .mismatch(a_mm), .err_cnt(a_err)
  );

  jk_cmd_seq #(.DEPTH(4), .HOLD(2), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_data(b_data),
    .cmd_ready(b_ready), .q_fb(qb), .j(b_j), .k(b_k), .busy(b_busy),
    .exp_q(b_expq), .mismatch(b_mm), .err_cnt(b_err)
  );

  // Downstream JK flops, sharing clock and reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) qa <= 1'b0;
    else case ({a_j, a_k})
      2'b10:   qa <= 1'b1;
      2'b01:   qa <= 1'b0;
      2'b11:   qa <= ~qa;
      default: qa <= qa;
    endcase
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) qb <= 1'b0;
    else case ({b_j, b_k})
      2'b10:   qb <= 1'b1;
      2'b01:   qb <= 1'b0;
      2'b11:   qb <= ~qb;
      default: qb <= qb;
    endcase
  end

  assign a_qfb = tie0 ? 1'b0 : qa;

  // Capture of every non-idle j/k drive on instance A while enabled.
  logic       mon_en = 1'b0;
  logic [1:0] cap [$];
  always @(negedge clk) begin
    if (mon_en && (a_j || a_k)) cap.push_back({a_j, a_k});
  end

  logic [1:0] t2_cmd [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
  logic [1:0] t2_jk  [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00};
  logic       t2_q   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] t3_cmd [7] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [1:0] t6_cmd [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    // ---- reset state ----
    #1;
    check("rst_jk",    {a_j, a_k}, 2'b00);
    check("rst_ready", a_ready, 1'b1);
    check("rst_busy",  a_busy, 1'b0);
    check("rst_expq",  a_expq, 1'b0);
    check("rst_mm",    a_mm, 1'b0);
    check("rst_err",   a_err, 8'd0);
    tick();
    rst = 1'b1;
    tick();

    // ---- T2: HOLD=1, four back-to-back commands ----
    a_valid = 1'b1;
    a_data  = t2_cmd[0];
    for (int c = 0; c <= 9; c++) begin
      tick();
      if (c >= 1 && c <= 8)
        check($sformatf("t2_jk_%0d", c), {a_j, a_k}, t2_jk[c-1]);
      if (c == 2 || c == 4 || c == 6 || c == 8)
        check($sformatf("t2_expq_%0d", c), a_expq, t2_q[c/2-1]);
      check($sformatf("t2_mm_%0d", c), a_mm, 1'b0);
      if (c <= 2) a_data = t2_cmd[c+1];
      if (c == 3) a_valid = 1'b0;
    end
    check("t2_err", a_err, 8'd0);

    // ---- T3: seven commands into a 4-deep FIFO ----
    cap.delete();
    mon_en  = 1'b1;
    check("t3_ready_init", a_ready, 1'b1);
    a_valid = 1'b1;
    a_data  = t3_cmd[0];
    for (int c = 0; c <= 15; c++) begin
      tick();
      if (c <= 5) begin
        check($sformatf("t3_ready_%0d", c), a_ready, 1'b1);
        a_data = t3_cmd[c+1];
      end
      if (c == 6) begin
        check("t3_full", a_ready, 1'b0);
        a_data = 2'b11;  // offered while full, must be refused
      end
      if (c == 7) begin
        check("t3_ready_again", a_ready, 1'b1);
        a_valid = 1'b0;
      end
      if (c == 14) check("t3_busy_check", a_busy, 1'b1);
      if (c == 15) check("t3_busy_drop", a_busy, 1'b0);
    end
    mon_en = 1'b0;
    check("t3_drive_count", cap.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < cap.size()) check($sformatf("t3_cmd_%0d", i), cap[i], t3_cmd[i]);
    end
    check("t3_err", a_err, 8'd0);

    // ---- T4: q_fb tied low, forced mismatches and saturation ----
    tie0    = 1'b1;
    a_valid = 1'b1;
    a_data  = 2'b10;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    check("t4_mm_pre", a_mm, 1'b0);
    tick();
    check("t4_mm_pulse", a_mm, 1'b1);
    check("t4_err_1", a_err, 8'd1);
    tick();
    check("t4_mm_end", a_mm, 1'b0);
    for (int i = 1; i < 300; i++) begin
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      tick();
      tick();
      tick();
      if (i == 253) check("t4_err_254", a_err, 8'd254);
      if (i == 254) check("t4_err_255", a_err, 8'd255);
      if (i == 299) begin
        check("t4_mm_last", a_mm, 1'b1);
        check("t4_err_sat", a_err, 8'd255);
      end
    end
    tick();
    tie0 = 1'b0;

    // ---- T1: async reset mid-DRIVE ----
    a_valid = 1'b1;
    a_data  = 2'b11;
    tick();
    a_data  = 2'b10;
    tick();
    a_valid = 1'b0;
    check("t1_in_drive", {a_j, a_k}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check("t1_jk",    {a_j, a_k}, 2'b00);
    check("t1_ready", a_ready, 1'b1);
    check("t1_busy",  a_busy, 1'b0);
    check("t1_err",   a_err, 8'd0);
    check("t1_expq",  a_expq, 1'b0);
    tick();
    rst = 1'b1;

    // ---- T6: reset with commands queued ----
    a_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a_data = t6_cmd[c];
      tick();
    end
    a_valid = 1'b0;
    check("t6_busy_pre", a_busy, 1'b1);
    check("t6_ready_pre", a_ready, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_busy_rst", a_busy, 1'b0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("t6_quiet_jk_%0d", c), {a_j, a_k}, 2'b00);
      check($sformatf("t6_quiet_busy_%0d", c), a_busy, 1'b0);
    end
    a_valid = 1'b1;
    a_data  = 2'b01;
    tick();
    a_valid = 1'b0;
    check("t6_new_wait", {a_j, a_k}, 2'b00);
    tick();
    check("t6_new_jk", {a_j, a_k}, 2'b01);
    tick();
    tick();
    check("t6_mm", a_mm, 1'b0);

    // ---- T5: HOLD=2 toggle ----
    b_valid = 1'b1;
    b_data  = 2'b11;
    tick();
    b_valid = 1'b0;
    tick();
    check("t5_jk_1", {b_j, b_k}, 2'b11);
    tick();
    check("t5_jk_2", {b_j, b_k}, 2'b11);
    check("t5_expq_1", b_expq, 1'b1);
    check("t5_q_1", qb, 1'b1);
    tick();
    check("t5_jk_3", {b_j, b_k}, 2'b00);
    check("t5_expq_check", b_expq, 1'b0);
    check("t5_busy", b_busy, 1'b1);
    tick();
    check("t5_mm", b_mm, 1'b0);
    check("t5_err", b_err, 8'd0);
    check("t5_idle", b_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
